// File: rtl/avl_mem_responder.sv
// Avalon-MM memory responder: word store with fixed-latency read pipeline,
// calibration delay, periodic refresh stalls and a registered ready.
module avl_mem_responder #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned ADDR_WIDTH       = 29,
  parameter int unsigned STORE_AW         = 10,
  parameter int unsigned RD_LATENCY       = 4,
  parameter int unsigned CAL_CYCLES       = 16,
  parameter int unsigned REFRESH_INTERVAL = 64,
  parameter int unsigned REFRESH_CYCLES   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  avl_write_req,
  input  logic                  avl_read_req,
  input  logic [ADDR_WIDTH-1:0] avl_addr,
  input  logic [DATA_WIDTH-1:0] avl_wdata,
  output logic                  avl_ready,
  output logic [DATA_WIDTH-1:0] avl_rdata,
  output logic                  avl_rdata_valid,
  output logic                  ram_rdy,
  output logic                  cmd_err,
  output logic [31:0]           wr_count,
  output logic [31:0]           rd_count
);

  localparam int unsigned CW    = $clog2(CAL_CYCLES + 1);
  localparam int unsigned TW    = $clog2(REFRESH_INTERVAL + 1);
  localparam int unsigned RW    = $clog2(REFRESH_CYCLES + 1);
  localparam int unsigned DEPTH = 1 << STORE_AW;

  localparam logic [CW-1:0] CAL_LAST = CW'(CAL_CYCLES - 1);
  localparam logic [TW-1:0] REF_LAST = TW'(REFRESH_INTERVAL - 1);
  localparam logic [RW-1:0] STL_LAST = RW'(REFRESH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_CAL,
    ST_RUN,
    ST_REFRESH
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cal_cnt_q;
  logic [TW-1:0]   ref_tmr_q;
  logic [RW-1:0]   stall_cnt_q;
  logic            ready_q;
  logic            ram_rdy_q;

  logic                  cmd_err_q;
  logic [31:0]           wr_count_q;
  logic [31:0]           rd_count_q;
  logic [RD_LATENCY-1:0] pv_q;
  logic [DATA_WIDTH-1:0] pd_q [RD_LATENCY];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] store_q [DEPTH];

  logic                  accept;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [STORE_AW-1:0]   idx;
  logic                  addr_hi_unused;

  // A simultaneous read is dropped in favour of the write.
  always_comb begin
    accept = ready_q & (avl_write_req | avl_read_req);
    wr_acc = accept & avl_write_req;
    rd_acc = accept & avl_read_req & ~avl_write_req;
    idx    = avl_addr[STORE_AW-1:0];
  end

  assign addr_hi_unused = ^avl_addr[ADDR_WIDTH-1:STORE_AW];

  // The refresh timer free-runs through REFRESH, so stall starts stay one
  // interval apart regardless of stall length.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_CAL;
      cal_cnt_q   <= '0;
      ref_tmr_q   <= '0;
      stall_cnt_q <= '0;
      ready_q     <= 1'b0;
      ram_rdy_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_CAL: begin
          if (cal_cnt_q == CAL_LAST) begin
            ram_rdy_q <= 1'b1;
            ready_q   <= 1'b1;
            ref_tmr_q <= '0;
            state_q   <= ST_RUN;
          end else begin
            cal_cnt_q <= cal_cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (ref_tmr_q == REF_LAST) begin
            ready_q     <= 1'b0;
            ref_tmr_q   <= '0;
            stall_cnt_q <= '0;
            state_q     <= ST_REFRESH;
          end else begin
            ref_tmr_q <= ref_tmr_q + 1'b1;
          end
        end
        ST_REFRESH: begin
          ref_tmr_q <= ref_tmr_q + 1'b1;
          if (stall_cnt_q == STL_LAST) begin
            ready_q <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_CAL;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_err_q  <= 1'b0;
      wr_count_q <= '0;
      rd_count_q <= '0;
      pv_q       <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (accept && avl_write_req && avl_read_req) begin
        cmd_err_q <= 1'b1;
      end
      if (wr_acc) begin
        wr_count_q <= wr_count_q + 32'd1;
      end
      if (rd_acc) begin
        rd_count_q <= rd_count_q + 32'd1;
      end
      pv_q[0] <= rd_acc;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
      end
      rvalid_q <= pv_q[RD_LATENCY-1];
      rdata_q  <= pd_q[RD_LATENCY-1];
    end
  end

  // Store and pipeline data carry no reset; validity lives in pv_q.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      store_q[idx] <= avl_wdata;
    end
    pd_q[0] <= store_q[idx];
    for (int unsigned i = 1; i < RD_LATENCY; i++) begin
      pd_q[i] <= pd_q[i-1];
    end
  end

  assign avl_ready       = ready_q;
  assign ram_rdy         = ram_rdy_q;
  assign cmd_err         = cmd_err_q;
  assign wr_count        = wr_count_q;
  assign rd_count        = rd_count_q;
  assign avl_rdata       = rdata_q;
  assign avl_rdata_valid = rvalid_q;

endmodule

// File: tb/tb_avl_mem_responder.sv
// Randomized bench for avl_mem_responder against a cycle-indexed reference model.
module tb_avl_mem_responder;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 29;
  localparam int unsigned SAW   = 10;
  localparam int unsigned LAT   = 4;
  localparam int unsigned CAL   = 16;
  localparam int unsigned RI    = 64;
  localparam int unsigned RC    = 3;
  localparam int unsigned DEPTH = 1 << SAW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          avl_write_req = 1'b0;
  logic          avl_read_req = 1'b0;
  logic [AW-1:0] avl_addr = '0;
  logic [DW-1:0] avl_wdata = '0;
  logic          avl_ready;
  logic [DW-1:0] avl_rdata;
  logic          avl_rdata_valid;
  logic          ram_rdy;
  logic          cmd_err;
  logic [31:0]   wr_count;
  logic [31:0]   rd_count;

  avl_mem_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STORE_AW(SAW), .RD_LATENCY(LAT),
    .CAL_CYCLES(CAL), .REFRESH_INTERVAL(RI), .REFRESH_CYCLES(RC)
  ) dut (
    .clk(clk), .reset(reset),
    .avl_write_req(avl_write_req), .avl_read_req(avl_read_req),
    .avl_addr(avl_addr), .avl_wdata(avl_wdata),
    .avl_ready(avl_ready), .avl_rdata(avl_rdata), .avl_rdata_valid(avl_rdata_valid),
    .ram_rdy(ram_rdy), .cmd_err(cmd_err), .wr_count(wr_count), .rd_count(rd_count)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: readiness is a pure function of clean edges since reset.
  typedef struct {
    int          due;
    logic [31:0] data;
    bit          known;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem_m [DEPTH];
  bit          known_m [DEPTH];
  int          cyc = 0;
  int          e_m = 0;
  logic [31:0] wr_m = 0;
  logic [31:0] rd_m = 0;
  bit          err_m = 0;
  bit          started = 0;
  int unsigned vcount = 0;
  logic [31:0] last_rdata = '0;

  function automatic bit ram_m(input int e);
    return e >= int'(CAL);
  endfunction

  function automatic bit rdy_m(input int e);
    int k;
    k = e - int'(CAL);
    if (e < int'(CAL)) return 1'b0;
    return !(k >= int'(RI) && (k % int'(RI)) < int'(RC));
  endfunction

  always @(posedge clk) begin
    int a;
    exp_t x;
    cyc++;
    started = 1;
    if (reset) begin
      e_m = 0; q.delete(); wr_m = 0; rd_m = 0; err_m = 0;
    end else begin
      a = int'(avl_addr % AW'(DEPTH));
      if (rdy_m(e_m) && (avl_write_req || avl_read_req)) begin
        if (avl_write_req) begin
          mem_m[a] = avl_wdata; known_m[a] = 1; wr_m = wr_m + 1;
          if (avl_read_req) err_m = 1;
        end else begin
          x.due = cyc + int'(LAT); x.data = mem_m[a]; x.known = known_m[a];
          q.push_back(x);
          rd_m = rd_m + 1;
        end
      end
      e_m++;
    end
  end

  always @(negedge clk) begin
    bit exp_v;
    if (started) begin
      check("ready", {31'd0, avl_ready}, {31'd0, rdy_m(e_m)});
      check("ram_rdy", {31'd0, ram_rdy}, {31'd0, ram_m(e_m)});
      check("wr_count", wr_count, wr_m);
      check("rd_count", rd_count, rd_m);
      check("cmd_err", {31'd0, cmd_err}, {31'd0, err_m});
      exp_v = (q.size() > 0) && (q[0].due == cyc);
      check("rvalid", {31'd0, avl_rdata_valid}, {31'd0, exp_v});
      if (avl_rdata_valid) begin
        vcount++;
        last_rdata = avl_rdata;
      end
      if (exp_v) begin
        if (q[0].known) check("rdata", avl_rdata, q[0].data);
        void'(q.pop_front());
      end
      while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
    end
  end

  task automatic idle();
    avl_write_req = 1'b0; avl_read_req = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic do_cmd(input bit we, input bit re, input int unsigned a, input logic [31:0] d);
    int unsigned n;
    logic [31:0] av;
    n = 0;
    av = a;
    avl_write_req = we; avl_read_req = re; avl_addr = av[AW-1:0]; avl_wdata = d;
    while (!avl_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("cmd_timeout", {31'd0, avl_ready}, 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_ram_rdy(output int unsigned n);
    n = 0;
    while (!ram_rdy && n < 64) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int unsigned n;
    int unsigned exp_wr;
    int unsigned v0;
    logic [31:0] rd0;

    repeat (5) @(negedge clk);
    check("rst_ready", {31'd0, avl_ready}, 32'd0);
    check("rst_rdata", avl_rdata, 32'd0);
    check("rst_rvalid", {31'd0, avl_rdata_valid}, 32'd0);
    check("rst_wr_count", wr_count, 32'd0);
    reset = 1'b0;
    wait_ram_rdy(n);
    check("cal_cycles", n, CAL);

    // Continuous writes from the first ready cycle.
    for (int i = 0; i < 200; i++) begin
      avl_write_req = 1'b1;
      avl_addr = AW'($urandom_range(0, DEPTH - 1));
      avl_wdata = $urandom;
      @(negedge clk);
    end
    idle();
    exp_wr = 0;
    for (int k = 0; k < 200; k++) if (!(k >= int'(RI) && (k % int'(RI)) < int'(RC))) exp_wr++;
    check("refresh_wr_count", wr_count, exp_wr);
    check("refresh_wr_191", wr_count, 32'd191);

    for (int unsigned a = 0; a < DEPTH; a++) do_cmd(1'b1, 1'b0, a, $urandom);
    idle();

    rd0 = wr_count;
    for (int unsigned a = 0; a < 8; a++) do_cmd(1'b1, 1'b0, a, 32'hA0 + a);
    v0 = vcount;
    for (int unsigned a = 0; a < 8; a++) do_cmd(1'b0, 1'b1, a, 32'h0);
    idle();
    repeat (LAT + 2) @(negedge clk);
    check("wr8_delta", wr_count - rd0, 32'd8);
    check("rd8_valids", vcount - v0, 32'd8);
    check("rd8_last", last_rdata, 32'hA7);

    do_cmd(1'b1, 1'b0, 5, 32'h1234);
    do_cmd(1'b0, 1'b1, 5 + DEPTH, 32'h0);
    idle();
    repeat (LAT + 2) @(negedge clk);
    check("alias_raw", last_rdata, 32'h1234);

    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      r = $urandom_range(0, 3);
      avl_write_req = (r == 1);
      avl_read_req  = (r == 2) || (r == 3);
      avl_addr = AW'($urandom_range(0, 4 * DEPTH - 1));
      avl_wdata = $urandom;
      @(negedge clk);
    end
    idle();
    repeat (LAT + 2) @(negedge clk);

    check("cmd_err_pre", {31'd0, cmd_err}, 32'd0);
    rd0 = rd_count;
    v0 = vcount;
    do_cmd(1'b1, 1'b1, 9, 32'h55);
    idle();
    repeat (LAT + 3) @(negedge clk);
    check("both_cmd_err", {31'd0, cmd_err}, 32'd1);
    check("both_rd_count", rd_count, rd0);
    check("both_no_valid", vcount, v0);
    do_cmd(1'b0, 1'b1, 9, 32'h0);
    idle();
    repeat (LAT + 2) @(negedge clk);
    check("both_store9", last_rdata, 32'h55);
    check("cmd_err_sticky", {31'd0, cmd_err}, 32'd1);

    do_cmd(1'b0, 1'b1, 1, 32'h0);
    do_cmd(1'b0, 1'b1, 2, 32'h0);
    avl_read_req = 1'b1; avl_addr = AW'(3);
    reset = 1'b1;
    v0 = vcount;
    @(negedge clk);
    idle();
    check("midrst_ram_rdy", {31'd0, ram_rdy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_ram_rdy(n);
    check("recal_cycles", n, CAL);
    repeat (10) @(negedge clk);
    check("midrst_no_valid", vcount, v0);
    check("midrst_cmd_err", {31'd0, cmd_err}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/avl_mem_responder.md
# avl_mem_responder

Avalon-MM memory responder: the slave end of the request interface driven by the frame buffer. Accepts `avl_write_req`/`avl_read_req` commands, stores write data in an internal word array, and returns read data after a fixed pipeline latency. It models calibration, periodic refresh stalls and back-pressure on `avl_ready`. It stands in for the external memory interface in simulation and in on-chip loopback builds.

## Interface
- `DATA_WIDTH`, 32, word width.
- `ADDR_WIDTH`, 29, word address width.
- `STORE_AW`, 10, log2 of the internal store depth; only `avl_addr[STORE_AW-1:0]` is used.
- `RD_LATENCY`, 4, accept-to-data latency in cycles; must be ≥ 1.
- `CAL_CYCLES`, 16, cycles from reset release to `ram_rdy`.
- `REFRESH_INTERVAL`, 64, cycles between refresh stalls; must be > `REFRESH_CYCLES`.
- `REFRESH_CYCLES`, 3, stall length in cycles.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `avl_write_req` in 1: write command.
- `avl_read_req` in 1: read command.
- `avl_addr` in `ADDR_WIDTH`: command address.
- `avl_wdata` in `DATA_WIDTH`: write data.
- `avl_ready` out 1: registered; the command is accepted when high.
- `avl_rdata` out `DATA_WIDTH`: read data.
- `avl_rdata_valid` out 1: `avl_rdata` is valid.
- `ram_rdy` out 1: calibration is done.
- `cmd_err` out 1: sticky flag, set when both requests are high on an accept cycle.
- `wr_count` out 32: number of accepted writes.
- `rd_count` out 32: number of accepted reads.

## Operation
- Reset values: all outputs are 0. The calibration, refresh and counter registers clear. Store contents are not reset.
- States: CAL → RUN ↔ REFRESH.
- **CAL**
  - Counts `CAL_CYCLES` cycles; `avl_ready` = 0.
  - On terminal count: `ram_rdy` ← 1, enter RUN, and the refresh timer starts at 0.
- **RUN**
  - `avl_ready` = 1, except when the refresh timer reaches `REFRESH_INTERVAL-1`.
  - At that point: `avl_ready` ← 0, enter REFRESH, and the timer restarts.
- **REFRESH**
  - Holds `avl_ready` = 0 for `REFRESH_CYCLES` cycles, then returns to RUN.
  - The refresh timer keeps counting through REFRESH.
- **Accept** = `avl_ready` & (`avl_write_req` | `avl_read_req`), evaluated at the clock edge.
- **Write accept**
  - `store[avl_addr[STORE_AW-1:0]]` ← `avl_wdata`.
  - `wr_count` += 1.
- **Read accept**
  - The store word is sampled at the accept edge into stage 0 of an `RD_LATENCY`-deep valid/data shift pipeline.
  - `rd_count` += 1.
- **Both requests high on an accept cycle**
  - The write is performed; the read is dropped and `rd_count` does not increment.
  - `cmd_err` ← 1 and stays set until reset.
- **Address aliasing:** addresses ≥ 2^`STORE_AW` alias modulo the depth. No error is raised.
- **Read-after-write**
  - A write accepted on a later cycle does not alter data already in the pipeline.
  - A read accepted one cycle after a write to the same address returns the new data.
- **Requests while `avl_ready` = 0:** ignored, with no side effects. The requester must hold or retry.
- **Counters:** wrap modulo 2^32.
- **Reset mid-operation**
  - The pipeline is flushed: no `avl_rdata_valid` after reset.
  - The block returns to CAL and `ram_rdy` drops.

## Timing
- `ram_rdy` and the first `avl_ready` go high exactly `CAL_CYCLES` cycles after the first clock edge with `reset` low.
- Read accepted at edge N → `avl_rdata_valid` = 1 for the single cycle following edge N+`RD_LATENCY`.
- Back-to-back reads give back-to-back valid data in order, with no bubbles.
- Throughput is one command per cycle outside REFRESH.
- Refresh stalls start `REFRESH_INTERVAL` cycles apart. Each removes exactly `REFRESH_CYCLES` accept opportunities.
- `avl_ready` is a register output, with no combinational path from the request inputs.
- Reads already in flight complete during REFRESH: the pipeline never stalls.

## Test plan
- **Reset and calibration:** hold `reset` 5 cycles, then release → all outputs 0. `ram_rdy` and `avl_ready` rise 16 cycles after release.
- **Write then read back:** write addrs 0..7 with data 0xA0..0xA7, then read 0..7 back-to-back → 8 consecutive valid cycles, first valid 4 cycles after the first read accept, data 0xA0..0xA7, `wr_count` = 8, `rd_count` = 8.
- **Refresh stall:** hold `avl_write_req` continuously for 200 cycles after `ram_rdy` → `avl_ready` low for 3 cycles every 64. Accepted writes = 200 − 3 × (number of stalls in the window); this must equal `wr_count`.
- **Aliasing and RAW:** write 0x1234 to addr 5, then next cycle read addr 1029 (5 + 1024) → returns 0x1234.
- **Protocol error:** assert both requests with addr 9 and data 0x55 on an accept cycle → store[9] = 0x55, `cmd_err` = 1 and stays set, `rd_count` unchanged, no valid data returned.
- **Reset mid-read:** issue 3 reads, assert `reset` 2 cycles after the first accept → no `avl_rdata_valid` is seen afterwards, and `ram_rdy` = 0 until recalibration.
